// File: rtl/regbank_wr_arb.sv
// Write-port controller for the 32x32 register bank: arbitrates two writeback requesters
// onto the single write port and sequences a full-bank clear on command.
module regbank_wr_arb #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter bit          RR = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] dr0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [AW-1:0] dr1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    input  logic          clr,
    output logic          busy,
    output logic          write,
    output logic [AW-1:0] dr,
    output logic [DW-1:0] wrData
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    // One extra bit so the terminal index is compared without wrapping.
    localparam logic [AW:0] LastIdx = {1'b0, {AW{1'b1}}};

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          write_q, write_d;
    logic [AW-1:0] dr_q, dr_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;

    // A clr pulse in idle takes the edge, so no grant may be offered alongside it.
    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        if (!reset && state_q == StIdle && !clr) begin
            if (req0 && req1) begin
                if (RR && !last_q) begin
                    ack1 = 1'b1;
                end else begin
                    ack0 = 1'b1;
                end
            end else if (req0) begin
                ack0 = 1'b1;
            end else if (req1) begin
                ack1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        write_d = 1'b0;
        dr_d    = dr_q;
        data_d  = data_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else if (ack0) begin
                    write_d = 1'b1;
                    dr_d    = dr0;
                    data_d  = data0;
                    last_d  = 1'b0;
                end else if (ack1) begin
                    write_d = 1'b1;
                    dr_d    = dr1;
                    data_d  = data1;
                    last_d  = 1'b1;
                end
            end
            StClear: begin
                write_d = 1'b1;
                dr_d    = cnt_q[AW-1:0];
                data_d  = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            write_q <= 1'b0;
            dr_q    <= '0;
            data_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            write_q <= write_d;
            dr_q    <= dr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign busy   = busy_q;
    assign write  = write_q;
    assign dr     = dr_q;
    assign wrData = data_q;

endmodule

// File: doc/regbank_wr_arb.md
Name: regbank_wr_arb

Overview:
Write-port controller for the 32x32 register bank, which has one write port and no hardwired zero register. It shares the single port between two requesters: requester 0 (ALU writeback) and requester 1 (load writeback). Arbitration is round-robin with a valid/ack handshake. It also sequences a bank clear on command by writing zero to every register through the normal write port. Its outputs drive the bank's write, dr and wrData inputs directly.

Parameters:
DW, 32, data width of wrData and requester data.
AW, 5, register address width; the bank depth is 2**AW.
RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with requester 0 always winning.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req0  in  1  requester 0 has a write pending.
dr0  in  AW  requester 0 destination register.
data0  in  DW  requester 0 write data.
ack0  out  1  combinational; requester 0 is granted this cycle.
req1  in  1  requester 1 has a write pending.
dr1  in  AW  requester 1 destination register.
data1  in  DW  requester 1 write data.
ack1  out  1  combinational; requester 1 is granted this cycle.
clr  in  1  one-cycle pulse; starts a clear of all registers.
busy  out  1  registered; high while a clear is in progress.
write  out  1  registered write enable to the bank.
dr  out  AW  registered bank destination register.
wrData  out  DW  registered bank write data.

Behaviour:
- FSM states: IDLE (arbitrate) and CLEAR. Reset puts the FSM in IDLE.
- Reset values: write=0, dr=0, wrData=0, busy=0, clear counter=0, last_grant=1 (so requester 0 wins first after reset).
- Handshake: a requester holds req/dr/data stable until it samples ack=1 at a posedge. That edge completes the transfer. The requester may raise a new req in the same cycle the transfer completes.
- ack is combinational from req0, req1, the FSM state and last_grant. At most one ack is high per cycle, and both acks are 0 in CLEAR and during reset.
- IDLE, one requester: the asserting requester is acked.
- IDLE, both requesting, RR=1: the requester not equal to last_grant wins. last_grant updates on every grant.
- IDLE, both requesting, RR=0: requester 0 wins.
- Granted transfer timing:
  - At the ack edge: write<=1, dr<=winner's dr, wrData<=winner's data.
  - The bank commits on the following edge, so latency from the ack edge to bank update is one cycle.
  - If there is no grant in a cycle, write<=0 at that edge.
- Equal destinations: when both requesters target the same dr, they serialize; the bank ends with the later grant's data.
- clr in IDLE:
  - At that edge, go to CLEAR, set busy<=1, and load counter=0.
  - No grant is issued at the clr edge, even if req0/req1 are high.
- CLEAR state, each cycle: write<=1, dr<=counter, wrData<=0, counter<=counter+1.
- CLEAR exit:
  - After the edge that issues dr=2**AW-1, go to IDLE with busy<=0, so 2**AW write cycles total.
  - Arbitration resumes in the first IDLE cycle.
  - write<=0 at that edge unless a grant occurs.
- clr while in CLEAR is ignored; the counter does not restart.
- Pending requests during CLEAR stay pending with ack=0, and are served afterwards under normal arbitration.
- Counter width is AW+1 so the terminal count is detected without wrap.
- reset mid-CLEAR or mid-transfer: at the reset edge, apply all reset values and abort the clear. A transfer not yet acked is not granted.
- reset has priority over clr and req.

Test Plan:
- Reset then single requester: req0=1, dr0=3, data0=30 -> ack0=1 in the first post-reset cycle; next cycle write=1, dr=3, wrData=30; reg[3]=30 one edge later; ack1 stays 0.
- Round-robin under contention, RR=1: req0 and req1 held high for 4 grants -> grant order 0,1,0,1 and write asserted 4 consecutive cycles. With RR=0 the same stimulus gives all grants to 0 while req0 stays high.
- Same-register race: dr0=dr1=7 with data0=70 and data1=71, both requesting simultaneously from reset -> grant 0 then 1; reg[7]=71.
- Clear sequence: preload regs with 10*k, then pulse clr -> busy high for exactly 32 cycles; dr steps 0..31 with wrData=0; all 32 regs read 0 afterwards.
- Request during clear: req1=1, dr1=5, data1=55 raised mid-clear -> ack1=0 while busy=1; ack1=1 in the first cycle after busy falls; reg[5]=55.
- Reset mid-clear: assert reset at counter=10 -> busy=0 and write=0 after that edge. A new clr then restarts the clear from dr=0.
